// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that time-shares one external combinational 4-bit
// adder/subtractor among NREQ requesters and returns tagged results.
module addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic [W-1:0]      au_a,
    output logic [W-1:0]      au_b,
    output logic              au_sub,
    input  logic              au_cy,
    input  logic [W-1:0]      au_f,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_f,
    output logic              rsp_cy,
    output logic              busy
);

    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   au_a_q, au_a_d;
    logic [W-1:0]   au_b_q, au_b_d;
    logic           au_sub_q, au_sub_d;
    logic [W-1:0]   rsp_f_q, rsp_f_d;
    logic           rsp_cy_q, rsp_cy_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = IDW'((32'(rr_ptr_q) + k) % NREQ_U);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign a_sel = W'(req_a >> (32'(win_id) * W));
    assign b_sel = W'(req_b >> (32'(win_id) * W));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        au_a_d      = au_a_q;
        au_b_d      = au_b_q;
        au_sub_d    = au_sub_q;
        rsp_f_d     = rsp_f_q;
        rsp_cy_d    = rsp_cy_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready = NREQ'(1) << win_id;
                    au_a_d    = a_sel;
                    au_b_d    = b_sel;
                    au_sub_d  = req_sub[win_id];
                    id_d      = win_id;
                    rr_ptr_d  = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_f_d     = au_f;
                rsp_cy_d    = au_cy;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            au_a_q      <= '0;
            au_b_q      <= '0;
            au_sub_q    <= 1'b0;
            rsp_f_q     <= '0;
            rsp_cy_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            au_a_q      <= au_a_d;
            au_b_q      <= au_b_d;
            au_sub_q    <= au_sub_d;
            rsp_f_q     <= rsp_f_d;
            rsp_cy_q    <= rsp_cy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_sub    = au_sub_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_cy    = rsp_cy_q;
    assign busy      = (state_q != IDLE);

endmodule
